// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream reader.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  // Every bit of m_axis_tdata (and the skid data) takes this value in reset.
  localparam logic TDATA_RST_BIT = 1'b0;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Command, FIFO read-side and AXI-Stream master signals of the reader.
// master = the reader itself, slave = the environment driving it.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) ();

  logic              i_start;
  logic [LEN_W-1:0]  i_len;
  logic              o_busy;
  logic              o_done;
  logic              o_fifo_rd;
  logic [DATA_W-1:0] i_fifo_data;
  logic              i_fifo_empty;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;

  modport master (
    input  i_start, i_len, i_fifo_data, i_fifo_empty, m_axis_tready,
    output o_busy, o_done, o_fifo_rd, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output i_start, i_len, i_fifo_data, i_fifo_empty, m_axis_tready,
    input  o_busy, o_done, o_fifo_rd, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry registered output buffer (main + skid). The consumer only sees
// main; skid absorbs one word popped while main is stalled, so the upstream
// pop decision never depends combinationally on ready.
module axis_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  output logic              main_valid,
  output logic [DATA_W-1:0] main_data,
  output logic              skid_valid
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              hs;

  assign hs = main_valid_q && ready;

  // Next-state: drain main on handshake (refill from skid), then place any
  // pushed word in main if main is free after this cycle, else in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (hs) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
    // Upstream never pushes while skid is occupied, so the refill above and
    // this push cannot both target main in the same cycle.
    if (push) begin
      if (!main_valid_q || hs) begin
        main_data_d  = push_data;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = push_data;
        skid_valid_d = 1'b1;
      end
    end
  end

  // Buffer registers; reset empties both entries and clears the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= {DATA_W{TDATA_RST_BIT}};
      skid_valid_q <= 1'b0;
      skid_data_q  <= {DATA_W{TDATA_RST_BIT}};
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign main_valid = main_valid_q;
  assign main_data  = main_data_q;
  assign skid_valid = skid_valid_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a commanded number of words from a show-ahead FIFO and emits them as
// an AXI-Stream packet with tlast on the final beat.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | waiting for i_start; zero-length start just pulses done
//   ST_STREAM | popping words (issue_rem > 0) while beats drain
//   ST_FLUSH  | all words popped; draining buffered beats to send_rem 0
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_stream_reader_if.master bus
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  issue_rem_q, issue_rem_d;
  logic [LEN_W-1:0]  send_rem_q, send_rem_d;
  logic              done_q, done_d;

  logic              fifo_rd;
  logic              hs;
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;

  // Pop decision uses only registered state and the FIFO flag, never tready.
  assign fifo_rd = (state_q == ST_STREAM) && !bus.i_fifo_empty &&
                   (issue_rem_q != '0) && !skid_valid;
  assign hs      = main_valid && bus.m_axis_tready;

  axis_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .clk        (clk),
    .rst        (reset),
    .push       (fifo_rd),
    .push_data  (bus.i_fifo_data),
    .ready      (bus.m_axis_tready),
    .main_valid (main_valid),
    .main_data  (main_data),
    .skid_valid (skid_valid)
  );

  // FSM next-state, counter updates and done pulse.
  always_comb begin
    state_d     = state_q;
    issue_rem_d = issue_rem_q;
    send_rem_d  = send_rem_q;
    done_d      = 1'b0;

    if (fifo_rd) begin
      issue_rem_d = issue_rem_q - LEN_W'(1);
    end
    if (hs && (send_rem_q != '0)) begin
      send_rem_d = send_rem_q - LEN_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_len != '0) begin
            issue_rem_d = bus.i_len;
            send_rem_d  = bus.i_len;
            state_d     = ST_STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (issue_rem_d == '0) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (send_rem_d == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      issue_rem_q <= '0;
      send_rem_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_rem_q <= issue_rem_d;
      send_rem_q  <= send_rem_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_done        = done_q;
  assign bus.o_fifo_rd     = fifo_rd;
  assign bus.m_axis_tvalid = main_valid;
  assign bus.m_axis_tdata  = main_data;
  assign bus.m_axis_tlast  = main_valid && (send_rem_q == LEN_W'(1));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural show-ahead FIFO, a negedge
// monitor that logs beats/pops/done, and directed plus random packets whose
// expected beat lists come from the words the bench itself wrote.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int LW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  fifo_stream_reader #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Show-ahead FIFO model
  logic [DW-1:0] fifo_mem [0:255];
  logic [7:0]    wr_ptr     = 8'd0;
  logic [7:0]    rd_ptr     = 8'd0;
  logic          fifo_flush = 1'b0;

  assign bus.i_fifo_empty = (rd_ptr == wr_ptr);
  assign bus.i_fifo_data  = fifo_mem[rd_ptr];

  // FIFO read pointer follows the DUT's pop strobe.
  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (bus.o_fifo_rd) rd_ptr <= rd_ptr + 8'd1;
  end

  int cyc = 0;
  // Free-running cycle count for beat timestamps.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state (written only by the monitor)
  logic [DW:0]   beat_log [0:1023];
  int            beat_cyc [0:1023];
  int            beat_n    = 0;
  int            pop_cnt   = 0;
  int            done_cnt  = 0;
  int            valid_cnt = 0;
  int            bad_rd    = 0;
  int            hold_err  = 0;
  int            tlast_err = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  // Observe the cycle's settled values; anything seen here takes effect at
  // the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.o_fifo_rd) pop_cnt++;
      if (bus.o_fifo_rd && bus.i_fifo_empty) bad_rd++;
      if (bus.o_done) done_cnt++;
      if (bus.m_axis_tvalid) valid_cnt++;
      if (bus.m_axis_tlast && !bus.m_axis_tvalid) tlast_err++;
      if (stall_prev && (!bus.m_axis_tvalid || bus.m_axis_tdata !== stall_data)) hold_err++;
      if (bus.m_axis_tvalid && bus.m_axis_tready && beat_n < 1024) begin
        beat_log[beat_n] = {bus.m_axis_tlast, bus.m_axis_tdata};
        beat_cyc[beat_n] = cyc;
        beat_n++;
      end
      stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
      stall_data = bus.m_axis_tdata;
    end
  end

  // Checking and stimulus (single process owns these)
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] words [$];
  int            b0, p0, d0, v0, n_len, pushed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic snap();
    b0 = beat_n; p0 = pop_cnt; d0 = done_cnt; v0 = valid_cnt;
  endtask

  task automatic start(input int len);
    bus.i_start = 1'b1;
    bus.i_len   = LW'(len);
    tick();
    bus.i_start = 1'b0;
    bus.i_len   = '0;
  endtask

  task automatic flush();
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (done_cnt != d0) break;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
  endtask

  // Expected packet: the L words written, in order, tlast only on the last.
  task automatic expect_pkt(input string tag, input int len);
    logic [DW:0] e;
    chk({tag, "_beats"}, 64'(beat_n - b0), 64'(len));
    chk({tag, "_pops"}, 64'(pop_cnt - p0), 64'(len));
    chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    for (int i = 0; i < len && i < beat_n - b0; i++) begin
      e = {(i == len - 1), words[i]};
      chk($sformatf("%s_beat%0d", tag, i), 64'(beat_log[b0 + i]), 64'(e));
    end
    chk({tag, "_busy_end"}, 64'(bus.o_busy), 64'd0);
    chk({tag, "_done_low"}, 64'(bus.o_done), 64'd0);
  endtask

  initial begin
    bus.i_start       = 1'b0;
    bus.i_len         = '0;
    bus.m_axis_tready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy",   64'(bus.o_busy), 64'd0);
    chk("rst_done",   64'(bus.o_done), 64'd0);
    chk("rst_rd",     64'(bus.o_fifo_rd), 64'd0);
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_tlast",  64'(bus.m_axis_tlast), 64'd0);
    chk("rst_tdata",  64'(bus.m_axis_tdata), 64'd0);
    reset = 1'b0;
    tick();

    // Basic 4-beat packet, tready high
    words.delete();
    for (int i = 0; i < 4; i++) begin
      words.push_back(DW'(32'h10 + i));
      push(words[i]);
    end
    bus.m_axis_tready = 1'b1;
    snap();
    start(4);
    chk("basic_busy", 64'(bus.o_busy), 64'd1);
    chk("basic_tvalid_c1", 64'(bus.m_axis_tvalid), 64'd0);
    chk("basic_rd_c1", 64'(bus.o_fifo_rd), 64'd1);
    tick();
    chk("basic_tvalid_c2", 64'(bus.m_axis_tvalid), 64'd1);
    chk("basic_tdata_c2", 64'(bus.m_axis_tdata), 64'h10);
    wait_done("basic", 50);
    expect_pkt("basic", 4);
    if (beat_n - b0 == 4) chk("basic_back2back", 64'(beat_cyc[b0 + 3] - beat_cyc[b0]), 64'd3);

    // Backpressure: tready low for 5 cycles once beat 0 is valid
    words.delete();
    for (int i = 0; i < 3; i++) begin
      words.push_back(DW'(32'hA0 + i));
      push(words[i]);
    end
    bus.m_axis_tready = 1'b0;
    snap();
    start(3);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_tvalid_held", 64'(bus.m_axis_tvalid), 64'd1);
      chk("bp_tdata_held", 64'(bus.m_axis_tdata), 64'hA0);
      tick();
    end
    chk("bp_pops_le2", 64'((pop_cnt - p0) <= 2), 64'd1);
    bus.m_axis_tready = 1'b1;
    wait_done("bp", 50);
    expect_pkt("bp", 3);

    // Starved FIFO: 2 of 4 words present, rest arrive 10 cycles later
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(DW'(32'hC0 + i));
    push(words[0]);
    push(words[1]);
    snap();
    start(4);
    repeat (10) tick();
    chk("starve_beats_mid", 64'(beat_n - b0), 64'd2);
    chk("starve_tvalid_mid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("starve_rd_mid", 64'(bus.o_fifo_rd), 64'd0);
    chk("starve_busy_mid", 64'(bus.o_busy), 64'd1);
    push(words[2]);
    tick();
    push(words[3]);
    wait_done("starve", 50);
    expect_pkt("starve", 4);

    // Zero length: done next cycle, no pops, no valid, stays idle
    push(32'hDEAD_0001);
    push(32'hDEAD_0002);
    snap();
    start(0);
    chk("zero_done", 64'(bus.o_done), 64'd1);
    chk("zero_busy", 64'(bus.o_busy), 64'd0);
    tick();
    chk("zero_done_low", 64'(bus.o_done), 64'd0);
    repeat (3) tick();
    chk("zero_pops", 64'(pop_cnt - p0), 64'd0);
    chk("zero_valid", 64'(valid_cnt - v0), 64'd0);
    chk("zero_done_cnt", 64'(done_cnt - d0), 64'd1);
    flush();

    // Start while busy is ignored
    words.delete();
    for (int i = 0; i < 7; i++) begin
      words.push_back(DW'(32'h700 + i));
      push(words[i]);
    end
    snap();
    start(7);
    tick();
    bus.i_start = 1'b1;
    bus.i_len   = LW'(3);
    tick();
    bus.i_start = 1'b0;
    bus.i_len   = '0;
    wait_done("busy_start", 60);
    expect_pkt("busy_start", 7);

    // Async reset mid-packet after 2 of 5 beats
    words.delete();
    for (int i = 0; i < 5; i++) begin
      words.push_back(DW'(32'h500 + i));
      push(words[i]);
    end
    snap();
    start(5);
    for (int n = 0; n < 20 && (beat_n - b0) < 2; n++) tick();
    chk("rstmid_beats_before", 64'(beat_n - b0), 64'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("rstmid_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rstmid_busy", 64'(bus.o_busy), 64'd0);
    chk("rstmid_rd", 64'(bus.o_fifo_rd), 64'd0);
    chk("rstmid_tlast", 64'(bus.m_axis_tlast), 64'd0);
    for (int i = 0; i < 2; i++)
      chk($sformatf("rstmid_beat%0d", i), 64'(beat_log[b0 + i]), 64'({1'b0, words[i]}));
    tick();
    tick();
    reset = 1'b0;
    flush();
    words.delete();
    words.push_back(32'h2222_0000);
    words.push_back(32'h2222_0001);
    push(words[0]);
    push(words[1]);
    snap();
    start(2);
    wait_done("post_rst", 40);
    expect_pkt("post_rst", 2);

    // Random packets: random lengths, data, FIFO fill timing and tready
    for (int p = 0; p < 8; p++) begin
      words.delete();
      n_len = $urandom_range(1, 20);
      for (int i = 0; i < n_len; i++) words.push_back(DW'($urandom));
      pushed = $urandom_range(0, n_len);
      for (int i = 0; i < pushed; i++) push(words[i]);
      snap();
      start(n_len);
      for (int n = 0; n < 600; n++) begin
        bus.m_axis_tready = ($urandom_range(0, 3) != 0);
        if (pushed < n_len && $urandom_range(0, 1) == 1) begin
          push(words[pushed]);
          pushed++;
        end
        tick();
        if (done_cnt != d0) break;
      end
      bus.m_axis_tready = 1'b1;
      chk($sformatf("rand%0d_done_seen", p), 64'(done_cnt - d0), 64'd1);
      expect_pkt($sformatf("rand%0d", p), n_len);
      flush();
    end

    // Global invariants collected by the monitor
    chk("never_rd_empty", 64'(bad_rd), 64'd0);
    chk("tdata_held_stall", 64'(hold_err), 64'd0);
    chk("tlast_only_valid", 64'(tlast_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Drains the show-ahead FIFO from its read side and emits an AXI-Stream-style master beat stream for the MM2S datapath. Each command carries a beat count: the block pops exactly that many words and marks the last beat with tlast. A 2-entry registered output (main + skid) means m_axis_tready never combinationally drives o_fifo_rd.

Parameters:
DATA_W, 32, width of the FIFO word and of m_axis_tdata; must equal the FIFO's FIFO_WIDTH
LEN_W, 16, width of the beat-count command; maximum packet is 2^LEN_W-1 beats

Ports:
clk  input  1  single clock; all state on posedge
reset  input  1  asynchronous, active-high reset; clears all state immediately
i_start  input  1  command strobe; accepted only when o_busy==0
i_len  input  LEN_W  beats in the packet; sampled with an accepted i_start
o_busy  output  1  high from the cycle after an accepted start until o_done
o_done  output  1  one-cycle pulse when the packet is complete
o_fifo_rd  output  1  pop strobe to the FIFO's i_rd
i_fifo_data  input  DATA_W  FIFO head word (show-ahead, valid while !i_fifo_empty)
i_fifo_empty  input  1  FIFO empty flag
m_axis_tvalid  output  1  output beat valid
m_axis_tready  input  1  downstream accept
m_axis_tdata  output  DATA_W  output beat data
m_axis_tlast  output  1  high on the final beat of the packet

Behaviour:
- Reset (async, active-high): state=IDLE; o_busy, o_done, o_fifo_rd, m_axis_tvalid and m_axis_tlast are 0; m_axis_tdata=0; both buffer entries invalid; counters 0. Reset mid-packet abandons the packet. Words already popped are lost. The FIFO contents are not touched.
- States are IDLE, STREAM and FLUSH.
- IDLE, start with i_len!=0: on an i_start edge, load issue_rem=i_len and send_rem=i_len, then go to STREAM.
- IDLE, start with i_len==0: no beats are produced and no pop occurs. o_done pulses the next cycle and the block stays IDLE (o_busy stays 0).
- IDLE, no start: i_start is ignored whenever the block is not in IDLE.
- STREAM, pop rule: o_fifo_rd = (state==STREAM) && !i_fifo_empty && issue_rem!=0 && !skid_valid. This uses registered terms plus FIFO flags only.
- STREAM, pop effect: each pop decrements issue_rem. The popped word (i_fifo_data in that same cycle) is captured into main if main is empty or is being consumed this cycle; otherwise it goes into skid.
- STREAM to FLUSH: move to FLUSH when issue_rem reaches 0.
- FLUSH: no pops. Stay until send_rem==0, then return to IDLE and pulse o_done in the same cycle that send_rem becomes 0.
- Output buffer:
  - m_axis_tvalid = main_valid.
  - A handshake is m_axis_tvalid && m_axis_tready. On a handshake, decrement send_rem and refill main from skid if skid_valid.
  - m_axis_tdata and m_axis_tvalid hold stable while tvalid && !tready.
- tlast: m_axis_tlast = main_valid && (send_rem==1). It is never asserted on any other beat.
- Latency: the first beat is valid 2 cycles after the accepted i_start, provided the FIFO is non-empty. Sustained throughput is 1 beat/cycle while tready=1 and the FIFO stays non-empty.
- FIFO empty mid-packet: stall pops only. Beats already buffered still drain and no bubble data is produced.
- Simultaneous pop into a full main plus a handshake from main: the new word goes to main, not to skid.
- Skid full: skid_valid=1 blocks pops, so skid never overflows.
- Counter rule: counters are LEN_W bits and never wrap; decrements occur only when the counter is non-zero.

Decomposition:
- Shared package fifo_stream_pkg holds the state enum typedef (IDLE/STREAM/FLUSH, 2 bits) and a localparam for the reset tdata value.
- One sub-module, axis_skid_buf, holds the main+skid registers and the valid/ready logic, parameterised by DATA_W.
- The top level keeps the FSM, the counters, and o_fifo_rd.

Test Plan:
- Basic packet: FIFO preloaded with 0x10..0x13, i_start with i_len=4, tready=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles, tlast only on 0x13, exactly 4 pops, o_done 1 cycle, o_busy falls.
- Backpressure: i_len=3, tready low for 5 cycles after the first beat valid -> tdata held at beat 0, at most 2 words popped while stalled, all 3 beats delivered in order after tready=1.
- Starved FIFO: i_len=4 with only 2 words present, the remaining 2 written 10 cycles later -> o_fifo_rd=0 while empty, no spurious tvalid, tlast on the 4th beat.
- Zero length: i_len=0 -> o_done pulse next cycle, zero pops, tvalid never asserted.
- Start while busy: second i_start during STREAM with i_len=7 -> ignored, first packet's length governs tlast.
- Async reset mid-packet: reset asserted between clock edges after 2 of 5 beats -> tvalid, o_busy, o_fifo_rd drop immediately; a new i_start with i_len=2 after release -> correct 2-beat packet.
